// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection phase scheduler.
// Latency: n/a (types, constants and a lamp helper only).
// Backpressure: n/a.
package traffic_pkg;

    // Phase encodings; the numeric values are visible on the phase debug port.
    typedef enum logic [2:0] {
        ST_ALL_RED_NS = 3'd0,
        ST_NS_GREEN   = 3'd1,
        ST_NS_YELLOW  = 3'd2,
        ST_ALL_RED_EW = 3'd3,
        ST_EW_GREEN   = 3'd4,
        ST_EW_YELLOW  = 3'd5,
        ST_HOLD       = 3'd6
    } phase_e;

    // Bit positions inside a light triplet.
    localparam int LIGHT_GREEN  = 0;
    localparam int LIGHT_YELLOW = 1;
    localparam int LIGHT_RED    = 2;

    // Direction that most recently had a green.
    typedef enum logic {
        DIR_NS = 1'b0,
        DIR_EW = 1'b1
    } dir_e;

    // One-hot lamp pattern with only the given bit lit.
    function automatic logic [2:0] lamp(input int idx);
        return 3'b001 << idx;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable remaining-time down-counter for the current phase.
// Latency: load or decrement visible one clk after the edge that applies it.
// Backpressure: none; decrements only on tick with en=1, holds at zero.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (resets to RST_VAL)
//   en_i, tick_i     global enable and one-second pulse
//   load_i           load load_value_i this edge (has priority over decrement)
//   remain_o, zero_o current count and count==0 flag
module phase_timer #(
    parameter int                 W       = 5,
    parameter logic [W-1:0]       RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         tick_i,
    input  logic         load_i,
    input  logic [W-1:0] load_value_i,
    output logic [W-1:0] remain_o,
    output logic         zero_o
);

    logic [W-1:0] remain_q;
    logic [W-1:0] remain_d;

    always_comb begin
        remain_d = remain_q;
        if (load_i) begin
            remain_d = load_value_i;
        end else if (en_i && tick_i && (remain_q != '0)) begin
            remain_d = remain_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain_q <= RST_VAL;
        end else begin
            remain_q <= remain_d;
        end
    end

    assign remain_o = remain_q;
    assign zero_o   = (remain_q == '0);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-road traffic phase sequencer with pedestrian requests and emergency hold.
// Latency: phase changes on the clk edge of the expiring tick (emergency: next edge, no tick).
// Backpressure: none; en=0 freezes phase, timer and last direction, requests still latch.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   en, tick                    global enable, one-clock pulse per second
//   ped_req_ns, ped_req_ew      pedestrian requests (pulse or level), latched
//   emerg                       emergency preemption level
//   ns_light, ew_light          {red, yellow, green} one-hot triplets
//   walk_ns, walk_ew            walk lamps, lit for a whole green if requested at entry
//   remain                      ticks left in the current phase (0 in HOLD)
//   phase                       current phase encoding
module intersection_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int pTIME_GREEN   = 15,
    parameter int pTIME_YELLOW  = 3,
    parameter int pTIME_ALL_RED = 2,
    parameter int pMIN_GREEN    = 5,
    parameter int pCNT_WIDTH    = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  tick,
    input  logic                  ped_req_ns,
    input  logic                  ped_req_ew,
    input  logic                  emerg,
    output logic [2:0]            ns_light,
    output logic [2:0]            ew_light,
    output logic                  walk_ns,
    output logic                  walk_ew,
    output logic [pCNT_WIDTH-1:0] remain,
    output logic [2:0]            phase
);

    localparam logic [pCNT_WIDTH-1:0] DUR_GREEN   = pCNT_WIDTH'(pTIME_GREEN - 1);
    localparam logic [pCNT_WIDTH-1:0] DUR_YELLOW  = pCNT_WIDTH'(pTIME_YELLOW - 1);
    localparam logic [pCNT_WIDTH-1:0] DUR_ALL_RED = pCNT_WIDTH'(pTIME_ALL_RED - 1);
    // Green may end early once remain has dropped to this value, which
    // guarantees at least pMIN_GREEN ticks of green.
    localparam logic [pCNT_WIDTH:0]   EARLY_LIM   = (pCNT_WIDTH+1)'(pTIME_GREEN - pMIN_GREEN);

    phase_e                  state_q, state_d;
    dir_e                    last_dir_q, last_dir_d;
    logic                    req_ns_q, req_ns_d;
    logic                    req_ew_q, req_ew_d;
    logic                    walk_ns_q, walk_ns_d;
    logic                    walk_ew_q, walk_ew_d;

    logic                    tmr_load;
    logic [pCNT_WIDTH-1:0]   tmr_load_value;
    logic [pCNT_WIDTH-1:0]   tmr_remain;
    logic                    tmr_zero;
    logic                    expire;
    logic                    early_ok;
    logic                    enter_ns_green;
    logic                    enter_ew_green;

    phase_timer #(
        .W       (pCNT_WIDTH),
        .RST_VAL (DUR_ALL_RED)
    ) u_phase_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en),
        .tick_i       (tick),
        .load_i       (tmr_load),
        .load_value_i (tmr_load_value),
        .remain_o     (tmr_remain),
        .zero_o       (tmr_zero)
    );

    assign expire   = tick && tmr_zero;
    assign early_ok = ({1'b0, tmr_remain} <= EARLY_LIM);

    // Next-phase logic. Every phase change reloads the timer on the same edge.
    always_comb begin
        state_d        = state_q;
        last_dir_d     = last_dir_q;
        walk_ns_d      = walk_ns_q;
        walk_ew_d      = walk_ew_q;
        tmr_load       = 1'b0;
        tmr_load_value = '0;

        if (en) begin
            unique case (state_q)
                ST_ALL_RED_NS: begin
                    if (expire) begin
                        tmr_load = 1'b1;
                        if (emerg) begin
                            state_d = ST_HOLD;
                        end else begin
                            state_d        = ST_NS_GREEN;
                            tmr_load_value = DUR_GREEN;
                            last_dir_d     = DIR_NS;
                            // A request arriving on the entry edge is served now.
                            walk_ns_d      = req_ns_q || ped_req_ns;
                        end
                    end
                end
                ST_NS_GREEN: begin
                    if (emerg || (tick && (tmr_zero || (req_ew_q && early_ok)))) begin
                        state_d        = ST_NS_YELLOW;
                        tmr_load       = 1'b1;
                        tmr_load_value = DUR_YELLOW;
                    end
                end
                ST_NS_YELLOW: begin
                    if (expire) begin
                        state_d        = ST_ALL_RED_EW;
                        tmr_load       = 1'b1;
                        tmr_load_value = DUR_ALL_RED;
                    end
                end
                ST_ALL_RED_EW: begin
                    if (expire) begin
                        tmr_load = 1'b1;
                        if (emerg) begin
                            state_d = ST_HOLD;
                        end else begin
                            state_d        = ST_EW_GREEN;
                            tmr_load_value = DUR_GREEN;
                            last_dir_d     = DIR_EW;
                            walk_ew_d      = req_ew_q || ped_req_ew;
                        end
                    end
                end
                ST_EW_GREEN: begin
                    if (emerg || (tick && (tmr_zero || (req_ns_q && early_ok)))) begin
                        state_d        = ST_EW_YELLOW;
                        tmr_load       = 1'b1;
                        tmr_load_value = DUR_YELLOW;
                    end
                end
                ST_EW_YELLOW: begin
                    if (expire) begin
                        state_d        = ST_ALL_RED_NS;
                        tmr_load       = 1'b1;
                        tmr_load_value = DUR_ALL_RED;
                    end
                end
                ST_HOLD: begin
                    // Resume by giving the green to the direction that did not have it last.
                    if (!emerg) begin
                        state_d        = (last_dir_q == DIR_EW) ? ST_ALL_RED_NS : ST_ALL_RED_EW;
                        tmr_load       = 1'b1;
                        tmr_load_value = DUR_ALL_RED;
                    end
                end
                default: begin
                    state_d        = ST_ALL_RED_NS;
                    tmr_load       = 1'b1;
                    tmr_load_value = DUR_ALL_RED;
                end
            endcase
        end
    end

    assign enter_ns_green = (state_q == ST_ALL_RED_NS) && (state_d == ST_NS_GREEN);
    assign enter_ew_green = (state_q == ST_ALL_RED_EW) && (state_d == ST_EW_GREEN);

    // Requests latch regardless of en; entering the served green clears them.
    assign req_ns_d = (req_ns_q || ped_req_ns) && !enter_ns_green;
    assign req_ew_d = (req_ew_q || ped_req_ew) && !enter_ew_green;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ALL_RED_NS;
            last_dir_q <= DIR_EW;
            req_ns_q   <= 1'b0;
            req_ew_q   <= 1'b0;
            walk_ns_q  <= 1'b0;
            walk_ew_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            req_ns_q   <= req_ns_d;
            req_ew_q   <= req_ew_d;
            walk_ns_q  <= walk_ns_d;
            walk_ew_q  <= walk_ew_d;
        end
    end

    // Lamp decode straight from the state register.
    always_comb begin
        ns_light = lamp(LIGHT_RED);
        ew_light = lamp(LIGHT_RED);
        unique case (state_q)
            ST_NS_GREEN:  ns_light = lamp(LIGHT_GREEN);
            ST_NS_YELLOW: ns_light = lamp(LIGHT_YELLOW);
            ST_EW_GREEN:  ew_light = lamp(LIGHT_GREEN);
            ST_EW_YELLOW: ew_light = lamp(LIGHT_YELLOW);
            default: ;
        endcase
    end

    // The walk flag is captured at green entry and only shown during that green,
    // so an emergency cut to yellow drops the lamp immediately.
    assign walk_ns = walk_ns_q && (state_q == ST_NS_GREEN);
    assign walk_ew = walk_ew_q && (state_q == ST_EW_GREEN);
    assign remain  = tmr_remain;
    assign phase   = state_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Self-checking bench for intersection_phase_scheduler.
// Latency: expected record pushed when a cycle is driven, popped after it.
// Backpressure: n/a.
module tb_intersection_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       tick;
    logic       ped_req_ns;
    logic       ped_req_ew;
    logic       emerg;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk_ns;
    logic       walk_ew;
    logic [4:0] remain;
    logic [2:0] phase;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] ph;
        logic [4:0] rem;
        logic       wns;
        logic       wew;
    } exp_t;

    typedef struct {
        logic [2:0] ph;
        int         ticks;
    } phase_vec_t;

    exp_t  sb[$];
    string sb_name[$];

    intersection_phase_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .tick       (tick),
        .ped_req_ns (ped_req_ns),
        .ped_req_ew (ped_req_ew),
        .emerg      (emerg),
        .ns_light   (ns_light),
        .ew_light   (ew_light),
        .walk_ns    (walk_ns),
        .walk_ew    (walk_ew),
        .remain     (remain),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] ns_exp(input logic [2:0] ph);
        case (ph)
            3'd1:    return 3'b001;
            3'd2:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] ew_exp(input logic [2:0] ph);
        case (ph)
            3'd4:    return 3'b001;
            3'd5:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    task automatic push_exp(input string nm, input logic [2:0] ph, input logic [4:0] rem,
                            input logic wns, input logic wew);
        exp_t e;
        e.ph = ph; e.rem = rem; e.wns = wns; e.wew = wew;
        sb.push_back(e);
        sb_name.push_back(nm);
    endtask

    task automatic check_front();
        exp_t        e;
        string       nm;
        logic [15:0] got;
        logic [15:0] want;
        e    = sb.pop_front();
        nm   = sb_name.pop_front();
        got  = {phase, remain, ns_light, ew_light, walk_ns, walk_ew};
        want = {e.ph, e.rem, ns_exp(e.ph), ew_exp(e.ph), e.wns, e.wew};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got phase=%0d remain=%0d ns=%b ew=%b walk_ns=%b walk_ew=%b, expected phase=%0d remain=%0d ns=%b ew=%b walk_ns=%b walk_ew=%b",
                     nm, phase, remain, ns_light, ew_light, walk_ns, walk_ew,
                     e.ph, e.rem, ns_exp(e.ph), ew_exp(e.ph), e.wns, e.wew);
        end
    endtask

    // One clock: drive at negedge, DUT edge in the middle, return at next negedge.
    task automatic cyc(input logic t);
        tick = t;
        @(negedge clk);
        tick       = 1'b0;
        ped_req_ns = 1'b0;
        ped_req_ew = 1'b0;
    endtask

    task automatic do_tick();
        cyc(1'b1);
        repeat (3) cyc(1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic step_exp(input string nm, input logic t, input logic [2:0] ph,
                            input logic [4:0] rem, input logic wns, input logic wew);
        push_exp(nm, ph, rem, wns, wew);
        cyc(t);
        check_front();
    endtask

    task automatic tick_exp(input string nm, input logic [2:0] ph, input logic [4:0] rem,
                            input logic wns, input logic wew);
        step_exp(nm, 1'b1, ph, rem, wns, wew);
        repeat (3) cyc(1'b0);
    endtask

    task automatic now_exp(input string nm, input logic [2:0] ph, input logic [4:0] rem,
                           input logic wns, input logic wew);
        push_exp(nm, ph, rem, wns, wew);
        check_front();
    endtask

    phase_vec_t cycle_tbl[6];

    initial begin
        cycle_tbl[0] = '{ph: 3'd0, ticks: 2};
        cycle_tbl[1] = '{ph: 3'd1, ticks: 15};
        cycle_tbl[2] = '{ph: 3'd2, ticks: 3};
        cycle_tbl[3] = '{ph: 3'd3, ticks: 2};
        cycle_tbl[4] = '{ph: 3'd4, ticks: 15};
        cycle_tbl[5] = '{ph: 3'd5, ticks: 3};

        rst_n = 1'b0; en = 1'b1; tick = 1'b0;
        ped_req_ns = 1'b0; ped_req_ew = 1'b0; emerg = 1'b0;
        repeat (2) @(negedge clk);
        now_exp("reset state", 3'd0, 5'd1, 1'b0, 1'b0);
        rst_n = 1'b1;

        // 1: full undisturbed cycle, checked before every tick.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < cycle_tbl[r].ticks; k++) begin
                now_exp($sformatf("cycle ph%0d k%0d", cycle_tbl[r].ph, k),
                        cycle_tbl[r].ph, 5'(cycle_tbl[r].ticks - 1 - k), 1'b0, 1'b0);
                do_tick();
            end
        end
        now_exp("cycle wrap", 3'd0, 5'd1, 1'b0, 1'b0);

        // 2: EW request at remain=12 cuts NS green to 5 ticks.
        ticks(2);
        now_exp("t2 ns green", 3'd1, 5'd14, 1'b0, 1'b0);
        ticks(2);
        ped_req_ew = 1'b1;
        cyc(1'b0);
        now_exp("t2 req at 12", 3'd1, 5'd12, 1'b0, 1'b0);
        tick_exp("t2 rem 11", 3'd1, 5'd11, 1'b0, 1'b0);
        tick_exp("t2 rem 10", 3'd1, 5'd10, 1'b0, 1'b0);
        tick_exp("t2 early yellow", 3'd2, 5'd2, 1'b0, 1'b0);
        ticks(2);
        tick_exp("t2 all red ew", 3'd3, 5'd1, 1'b0, 1'b0);
        do_tick();
        tick_exp("t2 ew walk", 3'd4, 5'd14, 1'b0, 1'b1);
        ticks(13);
        tick_exp("t2 ew walk end", 3'd4, 5'd0, 1'b0, 1'b1);
        tick_exp("t2 ew yellow", 3'd5, 5'd2, 1'b0, 1'b0);
        ticks(2);
        tick_exp("t2 all red ns", 3'd0, 5'd1, 1'b0, 1'b0);
        do_tick();
        tick_exp("t2 ns green again", 3'd1, 5'd14, 1'b0, 1'b0);

        // 3: req_ew was cleared; late EW request; own-direction NS request.
        ticks(3);
        tick_exp("t3 rem 10", 3'd1, 5'd10, 1'b0, 1'b0);
        tick_exp("t3 req_ew cleared", 3'd1, 5'd9, 1'b0, 1'b0);
        ticks(3);
        tick_exp("t3 rem 5", 3'd1, 5'd5, 1'b0, 1'b0);
        ped_req_ew = 1'b1;
        ped_req_ns = 1'b1;
        cyc(1'b0);
        tick_exp("t3 late req yellow", 3'd2, 5'd2, 1'b0, 1'b0);
        ticks(2);
        tick_exp("t3 all red ew", 3'd3, 5'd1, 1'b0, 1'b0);
        do_tick();
        tick_exp("t3 ew walk", 3'd4, 5'd14, 1'b0, 1'b1);
        ticks(3);
        tick_exp("t3 ew rem 10", 3'd4, 5'd10, 1'b0, 1'b1);
        tick_exp("t3 ew early yellow", 3'd5, 5'd2, 1'b0, 1'b0);
        ticks(2);
        tick_exp("t3 all red ns", 3'd0, 5'd1, 1'b0, 1'b0);
        do_tick();
        tick_exp("t3 ns walk served", 3'd1, 5'd14, 1'b1, 1'b0);

        // 4: emergency in EW green, hold, release.
        ticks(13);
        tick_exp("t4 ns walk end", 3'd1, 5'd0, 1'b1, 1'b0);
        tick_exp("t4 ns yellow", 3'd2, 5'd2, 1'b0, 1'b0);
        ticks(2);
        tick_exp("t4 all red ew", 3'd3, 5'd1, 1'b0, 1'b0);
        do_tick();
        tick_exp("t4 ew green", 3'd4, 5'd14, 1'b0, 1'b0);
        ticks(4);
        tick_exp("t4 ew rem 9", 3'd4, 5'd9, 1'b0, 1'b0);
        emerg = 1'b1;
        step_exp("t4 emerg yellow no tick", 1'b0, 3'd5, 5'd2, 1'b0, 1'b0);
        repeat (3) cyc(1'b0);
        ticks(2);
        tick_exp("t4 emerg all red", 3'd0, 5'd1, 1'b0, 1'b0);
        do_tick();
        tick_exp("t4 hold", 3'd6, 5'd0, 1'b0, 1'b0);
        ticks(2);
        now_exp("t4 hold stays", 3'd6, 5'd0, 1'b0, 1'b0);
        emerg = 1'b0;
        step_exp("t4 release", 1'b0, 3'd0, 5'd1, 1'b0, 1'b0);
        repeat (3) cyc(1'b0);
        do_tick();
        tick_exp("t4 ns green after hold", 3'd1, 5'd14, 1'b0, 1'b0);

        // 5: freeze with en=0 at remain=7.
        ticks(6);
        tick_exp("t5 rem 7", 3'd1, 5'd7, 1'b0, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            ped_req_ew = (i == 20);
            emerg      = (i == 30);
            cyc(i % 5 == 0);
            if (i == 25) now_exp("t5 frozen mid", 3'd1, 5'd7, 1'b0, 1'b0);
        end
        emerg = 1'b0;
        now_exp("t5 frozen end", 3'd1, 5'd7, 1'b0, 1'b0);
        en = 1'b1;
        tick_exp("t5 resume early yellow", 3'd2, 5'd2, 1'b0, 1'b0);

        // 6: asynchronous reset mid yellow; latched requests lost.
        #2;
        rst_n = 1'b0;
        #1;
        now_exp("t6 async reset", 3'd0, 5'd1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick_exp("t6 all red", 3'd0, 5'd0, 1'b0, 1'b0);
        ped_req_ns = 1'b1;
        step_exp("t6 req on entry edge", 1'b1, 3'd1, 5'd14, 1'b1, 1'b0);
        repeat (3) cyc(1'b0);
        ticks(4);
        tick_exp("t6 ew req lost", 3'd1, 5'd9, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
Two-road intersection controller that shares the crossing between the north-south (NS) and east-west (EW) approaches. It sequences green, yellow and all-red clearance phases from the one-second tick produced by second_counter (its last pulse). It arbitrates latched pedestrian requests, which can shorten the opposing green down to a minimum. An emergency input forces an all-red hold. Outputs drive two light triplets, walk lamps, and a remaining-seconds value for segment_display.

Parameters:
pTIME_GREEN, 15, green duration in ticks
pTIME_YELLOW, 3, yellow duration in ticks
pTIME_ALL_RED, 2, all-red clearance duration in ticks
pMIN_GREEN, 5, minimum green duration in ticks before early termination is allowed; 1 <= pMIN_GREEN <= pTIME_GREEN
pCNT_WIDTH, 5, width of the remaining-time counter; every duration must be <= 2^pCNT_WIDTH

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  global enable; 0 freezes state and counter
tick  in  1  one-clock pulse, once per second
ped_req_ns  in  1  pedestrian request to cross with NS traffic (pulse or level)
ped_req_ew  in  1  pedestrian request to cross with EW traffic
emerg  in  1  emergency preemption, level
ns_light  out  3  bit0 green, bit1 yellow, bit2 red; one-hot
ew_light  out  3  same encoding as ns_light
walk_ns  out  1  NS walk lamp
walk_ew  out  1  EW walk lamp
remain  out  pCNT_WIDTH  ticks left in the current phase; 0 in HOLD
phase  out  3  current state encoding, for debug and verification

Behaviour:
- States and encodings:
  - 0 ALL_RED_NS, 1 NS_GREEN, 2 NS_YELLOW
  - 3 ALL_RED_EW, 4 EW_GREEN, 5 EW_YELLOW
  - 6 HOLD
- Normal cycle: 0→1→2→3→4→5→0.
- Reset (async):
  - state ALL_RED_NS; remain = pTIME_ALL_RED-1.
  - both lights red (3'b100); walk 0; request latches 0; last_dir = EW.
- Phase timer:
  - On phase entry, remain loads duration-1.
  - On each tick with en=1, remain decrements. When a tick arrives with remain==0, the phase ends and the next state is entered on that same clock edge.
  - A phase of duration T therefore lasts exactly T ticks.
- Outputs are decoded combinationally from the state register:
  - ALL_RED_* and HOLD: both red.
  - NS_GREEN: ns green, ew red. NS_YELLOW: ns yellow, ew red. EW phases are symmetric.
- Request latches:
  - ped_req_x sets req_x. req_x clears on the edge that enters X_GREEN.
  - walk_x = 1 for all of X_GREEN if req_x was set at entry. Set and clear in the same cycle: clear wins, and that request is served.
  - Requests latch even when en=0 or during HOLD.
- Early termination in X_GREEN:
  - On a tick with en=1, if the opposing request is latched and remain <= pTIME_GREEN - pMIN_GREEN, go to X_YELLOW.
  - Hence green never lasts fewer than pMIN_GREEN ticks.
- Emergency (acts only when en=1):
  - In X_GREEN with emerg=1: on the next clk edge, with no tick needed, go to X_YELLOW; remain = pTIME_YELLOW-1; walk drops.
  - Yellow runs normally. At ALL_RED expiry with emerg=1, go to HOLD instead of the next green.
  - If emerg is asserted during ALL_RED, the phase completes and then enters HOLD.
  - In HOLD, when emerg=0: on the next edge go to ALL_RED_NS if last_dir==EW, else ALL_RED_EW; remain reloads.
  - last_dir updates on entry to each green.
- en=0: state, remain and last_dir hold; tick and emerg are ignored; outputs stay stable.
- Yellow phases are never shortened, whatever the requests or emergency.

Decomposition:
- Package traffic_pkg: state encodings, light bit indices (GREEN=0, YELLOW=1, RED=2), and direction constants.
- Sub-module phase_timer: loadable down-counter with en, tick, load and load_value, providing remain and zero outputs. The FSM and request latches live in the top of this block.

Test Plan:
1. Reset, en=1, tick every 4 clk: phase sequence 0(2 ticks)→1(15)→2(3)→3(2)→4(15)→5(3)→0. remain counts 14..0 in NS_GREEN. Exactly one light is on per triplet.
2. ped_req_ew pulse during NS_GREEN at remain=12: NS_YELLOW is entered on the tick where remain=10, i.e. a green of 5 ticks. EW_GREEN then has walk_ew=1, and req_ew clears on that entry.
3. ped_req_ew pulse at remain=5 in NS_GREEN: yellow on the next tick. ped_req_ns pulse during NS_GREEN: no early termination; served in the next NS_GREEN with walk_ns=1.
4. emerg=1 mid EW_GREEN (remain=9): EW_YELLOW on the next clk, then 3 ticks, then ALL_RED_NS for 2 ticks, then HOLD with all red and remain=0. Drop emerg: ALL_RED_NS, then NS_GREEN.
5. en=0 for 50 clk with ticks during NS_GREEN at remain=7: remain stays 7, state unchanged, ped_req_ew still latches. With en=1, the next tick ends green (7 <= 10).
6. rst_n low mid NS_YELLOW, asynchronous to clk: outputs are immediately all-red with walk 0, phase=0, remain=1. Previously latched requests are lost.
